izh_neuron_scheduler: RTL and testbench
=======================================

IZH_NEURON_SCHEDULER -- requirements
Module: izh_neuron_scheduler

Interface
REQ-001 The block SHALL have parameter N_NEURON, default 4, giving the number of neurons time-multiplexed onto one update datapath; legal values are 2, 4 or 8, and IDX_W = log2(N_NEURON).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port ena, input, 1 bit: global enable; when low the block freezes.
REQ-005 The block SHALL have port tick, input, 1 bit: a single-cycle pulse that starts one sweep of all neurons.
REQ-006 The block SHALL have port init, input, 1 bit: synchronous reload of all neuron states and abort of any sweep.
REQ-007 The block SHALL have ports dp_req (output, 1 bit), dp_idx (output, IDX_W bits), dp_v (output, 18 bits) and dp_u (output, 18 bits): the request to the datapath, carrying the neuron index and its v and u values in signed 2.16 format.
REQ-008 The block SHALL have ports dp_ack (input, 1 bit), dp_v_new (input, 18 bits), dp_u_new (input, 18 bits) and dp_spike (input, 1 bit): the datapath response, valid in the cycle dp_ack is high.
REQ-009 The block SHALL have ports busy (output, 1 bit), done (output, 1-cycle pulse), spikes (output, N_NEURON bits: the spike vector of the last sweep) and overrun (output, 1 bit: sticky).
REQ-010 The block SHALL have ports mon_sel (input, IDX_W bits) and mon_v (output, 8 bits); mon_v is the registered v[17:10] of neuron mon_sel.

Function
REQ-011 The block SHALL hold per-neuron 18-bit signed v and u in an internal register file.
REQ-012 The block SHALL implement a state machine with states IDLE, REQ, WB and DONE; busy SHALL be 1 in every state except IDLE.
REQ-013 IDLE: when tick=1 and ena=1, the block SHALL set idx=0, clear the spike accumulator and go to REQ.
REQ-014 REQ: dp_req=1; dp_idx, dp_v and dp_u SHALL be stable until the handshake (dp_req and dp_ack both 1 at a clock edge).
REQ-015 At the handshake the block SHALL write dp_v_new and dp_u_new into neuron idx, set bit idx of the accumulator if dp_spike=1, and go to WB.
REQ-016 WB: dp_req=0 for exactly one cycle; the block SHALL go to DONE if idx=N_NEURON-1, otherwise increment idx and go to REQ.
REQ-017 DONE: done=1 for one cycle and spikes is loaded from the accumulator; the next state SHALL be IDLE.
REQ-018 Latency: with dp_ack tied high, done SHALL be asserted in the cycle 2*N_NEURON+1 edges after the edge that samples tick (9 for N_NEURON=4).
REQ-019 A tick while busy=1, including in DONE, SHALL be ignored and SHALL set overrun; overrun is cleared only by init or reset.
REQ-020 When ena=0 the state machine, the registers and idx SHALL hold, dp_req SHALL be forced to 0, and dp_ack SHALL be ignored.
REQ-021 init=1 (acted on regardless of ena) SHALL have priority over tick and the handshake: it reloads every v to 0x34CCD and every u to 0x3CCCD, clears overrun, the accumulator and spikes, and goes to IDLE the next cycle.
REQ-022 dp_ack received while dp_req=0 SHALL be ignored.

Reset
REQ-023 While rst_n=0: state=IDLE, idx=0, every v=0x34CCD, every u=0x3CCCD, dp_req=0, dp_idx=0, dp_v=0, dp_u=0, busy=0, done=0, spikes=0, overrun=0, and mon_v=0xD3.
REQ-024 Reset assertion mid-sweep SHALL abort the sweep immediately and asynchronously; no write-back from the interrupted handshake SHALL occur.

Configuration
REQ-025 With IZH_SCHED_SPIKE_CNT_EN defined, the block SHALL add an output mon_cnt (8 bits) holding the per-neuron spike counter of neuron mon_sel.
REQ-026 Each spike counter SHALL increment at a handshake with dp_spike=1, saturate at 255, and be cleared by reset and init.
REQ-027 With IZH_SCHED_SPIKE_CNT_EN undefined, the port mon_cnt and the counters SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-028 Scenario: reset, then dp_ack tied 1, dp_v_new=idx*0x400, dp_spike=1 on idx 2 only, one tick -> done after 9 edges, spikes=0100, and mon_sel=3 gives mon_v=0x03.
REQ-029 Scenario: dp_ack delayed 3 cycles per request -> dp_v and dp_u held stable throughout, done after 2*4+1+4*3=21 edges.
REQ-030 Scenario: second tick 2 cycles after the first -> overrun=1, exactly one sweep and one done pulse; a following init -> overrun=0 and every v=0x34CCD.
REQ-031 Scenario: ena dropped for 5 cycles while in REQ for idx 1 -> dp_req=0 during the gap, then the sweep resumes at idx 1 and done is delayed by 5 cycles.
REQ-032 Scenario: rst_n pulsed low mid-WB -> all outputs at reset values at once, and the next tick starts at idx 0.
REQ-033 Scenario (IZH_SCHED_SPIKE_CNT_EN defined): 300 sweeps with dp_spike=1 -> mon_cnt=255 for every neuron; after init, mon_cnt=0.

Source files
------------

// File: rtl/izh_neuron_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : izh_neuron_scheduler
// Purpose  : Time-multiplexes N_NEURON Izhikevich neuron states (v, u in
//            signed 2.16 format) onto one shared update datapath. A tick
//            pulse starts one sweep. Each neuron is sent to the datapath with
//            a req/ack handshake and its result is written back. A spike
//            vector for the whole sweep is published with a done pulse.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   N_NEURON : neurons per sweep (2, 4 or 8); IDX_W = log2(N_NEURON)
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   ena                 : global enable; low freezes the block
//   tick                : 1-cycle pulse, starts a sweep
//   init                : synchronous reload of all neuron state, aborts sweep
//   dp_req/idx/v/u      : request to the datapath (held stable until ack)
//   dp_ack/v_new/u_new/
//   dp_spike            : datapath response, valid while dp_ack is high
//   busy                : high while a sweep is in progress
//   done                : 1-cycle pulse at end of sweep, spikes valid
//   spikes              : spike vector of the last completed sweep
//   overrun             : sticky, set by a tick that arrives while busy
//   mon_sel / mon_v     : registered v[17:10] of neuron mon_sel
//   mon_cnt             : (IZH_SCHED_SPIKE_CNT_EN only) saturating spike
//                         count of neuron mon_sel
// Build option
//   IZH_SCHED_SPIKE_CNT_EN : adds per-neuron 8-bit saturating spike counters
// ============================================================================
module izh_neuron_scheduler #(
    parameter int N_NEURON = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          tick,
    input  logic                          init,
    output logic                          dp_req,
    output logic [$clog2(N_NEURON)-1:0]   dp_idx,
    output logic [17:0]                   dp_v,
    output logic [17:0]                   dp_u,
    input  logic                          dp_ack,
    input  logic [17:0]                   dp_v_new,
    input  logic [17:0]                   dp_u_new,
    input  logic                          dp_spike,
    output logic                          busy,
    output logic                          done,
    output logic [N_NEURON-1:0]           spikes,
    output logic                          overrun,
    input  logic [$clog2(N_NEURON)-1:0]   mon_sel,
    output logic [7:0]                    mon_v
`ifdef IZH_SCHED_SPIKE_CNT_EN
    ,
    output logic [7:0]                    mon_cnt
`endif
);

    localparam int                IDX_W      = $clog2(N_NEURON);
    localparam logic [17:0]       c_V_INIT   = 18'h34CCD;
    localparam logic [17:0]       c_U_INIT   = 18'h3CCCD;
    localparam logic [7:0]        c_MON_INIT = c_V_INIT[17:10];
    localparam logic [IDX_W-1:0]  c_IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]  c_IDX_LAST = IDX_W'(N_NEURON - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [17:0]           r_v [N_NEURON];
    logic [17:0]           r_u [N_NEURON];
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_inc;
    logic [N_NEURON-1:0]   r_acc;
    logic [N_NEURON-1:0]   r_spikes;
    logic                  r_overrun;
    logic                  r_done;
    logic [IDX_W-1:0]      r_dp_idx;
    logic [17:0]           r_dp_v;
    logic [17:0]           r_dp_u;
    logic [7:0]            r_mon_v;

    // Single-cycle strobes decoded by the FSM; init already masks them all.
    logic                  w_start;
    logic                  w_hs;
    logic                  w_advance;
    logic                  w_finish;

    assign w_idx_inc = r_idx + c_IDX_ONE;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_hs        = 1'b0;
        w_advance   = 1'b0;
        w_finish    = 1'b0;
        busy        = (r_state != S_IDLE);
        // Request is masked while frozen, so an ack during the gap is ignored.
        dp_req      = ena && (r_state == S_REQ);

        if (ena) begin
            case (r_state)
                S_IDLE: begin
                    if (tick) begin
                        w_state_nxt = S_REQ;
                        w_start     = 1'b1;
                    end
                end
                S_REQ: begin
                    if (dp_ack) begin
                        w_state_nxt = S_WB;
                        w_hs        = 1'b1;
                    end
                end
                S_WB: begin
                    if (r_idx == c_IDX_LAST) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_REQ;
                        w_advance   = 1'b1;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                    w_finish    = 1'b1;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        // init outranks both a fresh tick and an in-flight handshake.
        if (init) begin
            w_state_nxt = S_IDLE;
            w_start     = 1'b0;
            w_hs        = 1'b0;
            w_advance   = 1'b0;
            w_finish    = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Register file, sweep index, request registers and status
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURON; i++) begin
                r_v[i] <= c_V_INIT;
                r_u[i] <= c_U_INIT;
            end
            r_idx     <= '0;
            r_acc     <= '0;
            r_spikes  <= '0;
            r_overrun <= 1'b0;
            r_done    <= 1'b0;
            r_dp_idx  <= '0;
            r_dp_v    <= '0;
            r_dp_u    <= '0;
            r_mon_v   <= c_MON_INIT;
        end else if (init) begin
            for (int i = 0; i < N_NEURON; i++) begin
                r_v[i] <= c_V_INIT;
                r_u[i] <= c_U_INIT;
            end
            r_idx     <= '0;
            r_acc     <= '0;
            r_spikes  <= '0;
            r_overrun <= 1'b0;
            r_done    <= 1'b0;
            r_dp_idx  <= '0;
            r_dp_v    <= '0;
            r_dp_u    <= '0;
            r_mon_v   <= c_MON_INIT;
        end else begin
            r_done <= 1'b0;
            if (ena) begin
                if (tick && (r_state != S_IDLE)) begin
                    r_overrun <= 1'b1;
                end

                // The request registers are only loaded on entry to REQ,
                // which keeps idx/v/u stable until the handshake.
                if (w_start) begin
                    r_idx    <= '0;
                    r_acc    <= '0;
                    r_dp_idx <= '0;
                    r_dp_v   <= r_v[0];
                    r_dp_u   <= r_u[0];
                end

                if (w_hs) begin
                    r_v[r_idx] <= dp_v_new;
                    r_u[r_idx] <= dp_u_new;
                    if (dp_spike) begin
                        r_acc[r_idx] <= 1'b1;
                    end
                end

                // Neuron idx+1 has not been written this sweep, so reading
                // it in the WB cycle returns its pre-sweep state.
                if (w_advance) begin
                    r_idx    <= w_idx_inc;
                    r_dp_idx <= w_idx_inc;
                    r_dp_v   <= r_v[w_idx_inc];
                    r_dp_u   <= r_u[w_idx_inc];
                end

                if (w_finish) begin
                    r_done   <= 1'b1;
                    r_spikes <= r_acc;
                end

                r_mon_v <= r_v[mon_sel][17:10];
            end
        end
    end

    assign dp_idx  = r_dp_idx;
    assign dp_v    = r_dp_v;
    assign dp_u    = r_dp_u;
    assign done    = r_done;
    assign spikes  = r_spikes;
    assign overrun = r_overrun;
    assign mon_v   = r_mon_v;

    // ------------------------------------------------------------------------
    // Optional per-neuron saturating spike counters
    // ------------------------------------------------------------------------
`ifdef IZH_SCHED_SPIKE_CNT_EN
    logic [7:0] r_cnt [N_NEURON];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURON; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (init) begin
            for (int i = 0; i < N_NEURON; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_hs && dp_spike && (r_cnt[r_idx] != 8'hFF)) begin
            r_cnt[r_idx] <= r_cnt[r_idx] + 8'd1;
        end
    end

    assign mon_cnt = r_cnt[mon_sel];
`else
    // Spike counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_izh_neuron_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_izh_neuron_scheduler
// Purpose  : Self-checking bench for izh_neuron_scheduler (N_NEURON = 4).
//            A table of sweep records drives a datapath responder and checks
//            latency, spike vector and monitored v; hand-written sequences
//            cover overrun, ena gaps, init and asynchronous reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_izh_neuron_scheduler;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n, ena, tick, init;
    logic        dp_req, dp_ack, dp_spike;
    logic [1:0]  dp_idx, mon_sel;
    logic [17:0] dp_v, dp_u, dp_v_new, dp_u_new;
    logic        busy, done, overrun;
    logic [3:0]  spikes;
    logic [7:0]  mon_v;
`ifdef IZH_SCHED_SPIKE_CNT_EN
    logic [7:0]  mon_cnt;
`endif

    izh_neuron_scheduler #(.N_NEURON(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .tick     (tick),
        .init     (init),
        .dp_req   (dp_req),
        .dp_idx   (dp_idx),
        .dp_v     (dp_v),
        .dp_u     (dp_u),
        .dp_ack   (dp_ack),
        .dp_v_new (dp_v_new),
        .dp_u_new (dp_u_new),
        .dp_spike (dp_spike),
        .busy     (busy),
        .done     (done),
        .spikes   (spikes),
        .overrun  (overrun),
        .mon_sel  (mon_sel),
        .mon_v    (mon_v)
`ifdef IZH_SCHED_SPIKE_CNT_EN
        ,
        .mon_cnt  (mon_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          delay;
        bit          tie;
        logic [17:0] vbase;
        logic [3:0]  spk;
        logic [1:0]  sel;
        int          exp_edges;
        logic [3:0]  exp_spikes;
        logic [7:0]  exp_mon;
    } vec_t;

    int          n_chk  = 0;
    int          n_fail = 0;

    logic [17:0] m_v [N];
    logic [17:0] m_u [N];

    int          cur_delay;
    bit          cur_tie;
    logic [17:0] cur_vbase;
    logic [3:0]  cur_spk;
    int          req_age;
    logic [17:0] held_v, held_u;
    int          edges;
    int          done_cnt;
    int          last_done_edge;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 18'h34CCD;
            m_u[i] = 18'h3CCCD;
        end
        req_age = 0;
    endtask

    // One clock: predict the handshake about to happen, advance, observe at
    // edge+1, then drive the datapath response for the next edge.
    task automatic step();
        logic        hs;
        logic [1:0]  hidx;
        logic [17:0] hv, hu;
        hs   = dp_req && dp_ack && !init && rst_n;
        hidx = dp_idx;
        hv   = dp_v_new;
        hu   = dp_u_new;
        @(posedge clk);
        #1;
        edges++;
        if (hs) begin
            m_v[hidx] = hv;
            m_u[hidx] = hu;
        end
        if (done) begin
            done_cnt++;
            last_done_edge = edges;
        end
        if (dp_req) begin
            req_age++;
            if (req_age == 1) begin
                check("dp_v", dp_v, m_v[dp_idx]);
                check("dp_u", dp_u, m_u[dp_idx]);
                held_v = dp_v;
                held_u = dp_u;
            end else begin
                check("dp_v_hold", dp_v, held_v);
                check("dp_u_hold", dp_u, held_u);
            end
        end else begin
            req_age = 0;
        end
        dp_ack   = cur_tie ? 1'b1 : (dp_req && (req_age > cur_delay));
        dp_v_new = cur_vbase + 18'(dp_idx) * 18'h400;
        dp_u_new = dp_v_new ^ 18'h15555;
        dp_spike = cur_spk[dp_idx];
    endtask

    task automatic wait_done(input int start_cnt);
        while ((done_cnt == start_cnt) && (edges < 300)) step();
        if (done_cnt == start_cnt) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: got no done after %0d edges", edges);
        end
    endtask

    task automatic run_sweep();
        int start;
        start = done_cnt;
        tick  = 1'b1;
        step();
        tick  = 1'b0;
        edges = 0;
        check("busy_start", busy, 1);
        wait_done(start);
    endtask

    vec_t vecs [4];

    initial begin
        int start;

        vecs[0] = '{delay: 0, tie: 1'b1, vbase: 18'h00000, spk: 4'b0100, sel: 2'd3,
                    exp_edges: 9,  exp_spikes: 4'b0100, exp_mon: 8'h03};
        vecs[1] = '{delay: 3, tie: 1'b0, vbase: 18'h01000, spk: 4'b1010, sel: 2'd1,
                    exp_edges: 21, exp_spikes: 4'b1010, exp_mon: 8'h05};
        vecs[2] = '{delay: 1, tie: 1'b0, vbase: 18'h20000, spk: 4'b1111, sel: 2'd0,
                    exp_edges: 13, exp_spikes: 4'b1111, exp_mon: 8'h80};
        vecs[3] = '{delay: 0, tie: 1'b0, vbase: 18'h3F000, spk: 4'b0000, sel: 2'd2,
                    exp_edges: 9,  exp_spikes: 4'b0000, exp_mon: 8'hFE};

        rst_n = 1'b0; ena = 1'b1; tick = 1'b0; init = 1'b0;
        dp_ack = 1'b0; dp_v_new = '0; dp_u_new = '0; dp_spike = 1'b0; mon_sel = 2'd0;
        cur_delay = 0; cur_tie = 1'b1; cur_vbase = '0; cur_spk = '0;
        edges = 0; done_cnt = 0; last_done_edge = 0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_dp_req", dp_req, 0);
        check("rst_dp_idx", dp_idx, 0);
        check("rst_dp_v", dp_v, 0);
        check("rst_dp_u", dp_u, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_spikes", spikes, 0);
        check("rst_overrun", overrun, 0);
        check("rst_mon_v", mon_v, 8'hD3);
        rst_n = 1'b1;
        step();

        // Table-driven sweeps
        for (int r = 0; r < 4; r++) begin
            cur_delay = vecs[r].delay;
            cur_tie   = vecs[r].tie;
            cur_vbase = vecs[r].vbase;
            cur_spk   = vecs[r].spk;
            run_sweep();
            check($sformatf("latency_row%0d", r), last_done_edge, vecs[r].exp_edges);
            check($sformatf("spikes_row%0d", r), spikes, vecs[r].exp_spikes);
            check($sformatf("busy_end_row%0d", r), busy, 0);
            step();
            check($sformatf("done_width_row%0d", r), done, 0);
            mon_sel = vecs[r].sel;
            step();
            step();
            check($sformatf("mon_v_row%0d", r), mon_v, vecs[r].exp_mon);
        end

        // Second tick two cycles after the first: one sweep, overrun set
        cur_tie = 1'b1; cur_spk = 4'b0000; cur_vbase = 18'h00800;
        start = done_cnt;
        tick = 1'b1;
        step();
        tick = 1'b0;
        edges = 0;
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (30) step();
        check("overrun_set", overrun, 1);
        check("overrun_one_done", done_cnt - start, 1);
        check("overrun_latency", last_done_edge, 9);

        // init clears overrun/spikes and reloads every v
        init = 1'b1;
        step();
        init = 1'b0;
        model_reset();
        check("init_overrun", overrun, 0);
        check("init_busy", busy, 0);
        for (int s = 0; s < 4; s++) begin
            mon_sel = 2'(s);
            step();
            step();
            check($sformatf("init_mon_v%0d", s), mon_v, 8'hD3);
        end

        // ena dropped for 5 cycles while requesting neuron 1
        cur_vbase = 18'h04000; cur_spk = 4'b0010;
        start = done_cnt;
        tick = 1'b1;
        step();
        tick = 1'b0;
        edges = 0;
        step();
        step();
        check("gap_pre_req", dp_req, 1);
        check("gap_pre_idx", dp_idx, 1);
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("gap_req_low%0d", k), dp_req, 0);
        end
        ena = 1'b1;
        #1;
        check("gap_resume_req", dp_req, 1);
        check("gap_resume_idx", dp_idx, 1);
        wait_done(start);
        check("gap_latency", last_done_edge, 14);
        check("gap_spikes", spikes, 4'b0010);

        // Asynchronous reset while in WB
        mon_sel = 2'd3;
        step();
        step();
        check("pre_rst_mon_v", mon_v, 8'h13);
        cur_vbase = 18'h08000; cur_spk = 4'b1111;
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        check("pre_rst_wb", dp_req, 0);
        check("pre_rst_overrun", overrun, 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_dp_req", dp_req, 0);
        check("arst_dp_idx", dp_idx, 0);
        check("arst_dp_v", dp_v, 0);
        check("arst_dp_u", dp_u, 0);
        check("arst_done", done, 0);
        check("arst_spikes", spikes, 0);
        check("arst_overrun", overrun, 0);
        check("arst_mon_v", mon_v, 8'hD3);
        step();
        rst_n = 1'b1;
        model_reset();
        step();
        start = done_cnt;
        tick = 1'b1;
        step();
        tick = 1'b0;
        edges = 0;
        check("restart_req", dp_req, 1);
        check("restart_idx", dp_idx, 0);
        check("restart_v", dp_v, 18'h34CCD);
        wait_done(start);
        check("restart_latency", last_done_edge, 9);
        check("restart_spikes", spikes, 4'b1111);

`ifdef IZH_SCHED_SPIKE_CNT_EN
        // Saturating spike counters
        cur_spk = 4'b1111;
        for (int w = 0; w < 300; w++) run_sweep();
        for (int s = 0; s < 4; s++) begin
            mon_sel = 2'(s);
            #1;
            check($sformatf("cnt_sat%0d", s), mon_cnt, 8'hFF);
        end
        init = 1'b1;
        step();
        init = 1'b0;
        model_reset();
        for (int s = 0; s < 4; s++) begin
            mon_sel = 2'(s);
            #1;
            check($sformatf("cnt_init%0d", s), mon_cnt, 8'h00);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
